// File: rtl/pipe_ctrl_pkg.sv
// Shared types and source/destination compare helpers for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef logic [1:0] fwd_sel_t;
    typedef logic [3:0] reg_idx_t;

    localparam fwd_sel_t FWD_RF  = 2'd0;
    localparam fwd_sel_t FWD_MEM = 2'd1;
    localparam fwd_sel_t FWD_WB  = 2'd2;

    // R15 is compared like any other register; the PC write path is not special-cased here.
    function automatic logic src_hit(
        input logic     use_src,
        input reg_idx_t src,
        input logic     wb_en,
        input reg_idx_t dest
    );
        return use_src & wb_en & (src == dest);
    endfunction

    function automatic fwd_sel_t fwd_pick(
        input reg_idx_t src,
        input logic     mem_wb_en,
        input reg_idx_t mem_dest,
        input logic     wb_wb_en,
        input reg_idx_t wb_dest
    );
        if (mem_wb_en && (mem_dest == src)) begin
            return FWD_MEM;
        end
        if (wb_wb_en && (wb_dest == src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detect on ID sources; with PIPE_CTRL_FWD_EN only load-use stalls
// and EX operand forward selects are produced.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
`ifdef PIPE_CTRL_FWD_EN
    input  logic [3:0] ex_src1,
    input  logic [3:0] ex_src2,
    input  logic [3:0] wb_dest,
    input  logic       wb_wb_en,
    output logic [1:0] fwd_sel1,
    output logic [1:0] fwd_sel2,
`endif
    input  logic [3:0] id_src1,
    input  logic [3:0] id_src2,
    input  logic       id_use1,
    input  logic       id_use2,
    input  logic [3:0] exe_dest,
    input  logic       exe_wb_en,
    input  logic       exe_mem_r_en,
    input  logic [3:0] mem_dest,
    input  logic       mem_wb_en,
    output logic       hazard
);

    logic ex_hit;

    assign ex_hit = src_hit(id_use1, id_src1, exe_wb_en, exe_dest)
                  | src_hit(id_use2, id_src2, exe_wb_en, exe_dest);

`ifdef PIPE_CTRL_FWD_EN
    // Only a load in EX cannot be bypassed: its data exists after MEM.
    assign hazard   = exe_mem_r_en & ex_hit;
    assign fwd_sel1 = fwd_pick(ex_src1, mem_wb_en, mem_dest, wb_wb_en, wb_dest);
    assign fwd_sel2 = fwd_pick(ex_src2, mem_wb_en, mem_dest, wb_wb_en, wb_dest);
`else
    logic mem_hit;
    logic unused_exe_mem_r_en;

    assign mem_hit = src_hit(id_use1, id_src1, mem_wb_en, mem_dest)
                   | src_hit(id_use2, id_src2, mem_wb_en, mem_dest);
    assign hazard  = ex_hit | mem_hit;
    assign unused_exe_mem_r_en = exe_mem_r_en;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline freeze/flush sequencer: memory wait FSM with timeout, branch flush, RAW stall, stall counter.
// Outputs are combinational from the current cycle; PIPE_CTRL_FWD_EN enables forwarding mode.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_acc,
    input  logic             mem_ready,
    input  logic             branch_taken,
`ifdef PIPE_CTRL_FWD_EN
    input  logic [3:0]       ex_src1,
    input  logic [3:0]       ex_src2,
    input  logic [3:0]       wb_dest,
    input  logic             wb_wb_en,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
`endif
    output logic             freeze_pc,
    output logic             freeze_ifid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             freeze_back,
    output logic             mem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic hazard;
    logic timeout_hit;
    logic mem_stall;

    hazard_detect u_hazard_detect (
`ifdef PIPE_CTRL_FWD_EN
        .ex_src1      (ex_src1),
        .ex_src2      (ex_src2),
        .wb_dest      (wb_dest),
        .wb_wb_en     (wb_wb_en),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2),
`endif
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (hazard)
    );

    // A ready response on the limit cycle still wins over the timeout.
    assign timeout_hit = (state_q == MEM_WAIT) & mem_acc & ~mem_ready
                       & (wait_cnt_q == WC_W'(MEM_TIMEOUT));
    assign mem_stall   = mem_acc & ~mem_ready & ~timeout_hit;
    assign mem_req     = ~reset & mem_acc & ~timeout_hit;

    always_comb begin
        freeze_pc   = 1'b0;
        freeze_ifid = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        freeze_back = 1'b0;
        if (!reset) begin
            if (mem_stall) begin
                freeze_pc   = 1'b1;
                freeze_ifid = 1'b1;
                freeze_back = 1'b1;
            end else if (branch_taken) begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
            end else if (hazard) begin
                freeze_pc   = 1'b1;
                freeze_ifid = 1'b1;
                flush_idex  = 1'b1;
            end
        end
    end

    // Leaving MEM_WAIT covers ready, timeout and a dropped access request alike.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q | timeout_hit;
        if (state_q == RUN) begin
            if (mem_stall) begin
                state_d    = MEM_WAIT;
                wait_cnt_d = WC_W'(1);
            end
        end else begin
            if (mem_stall) begin
                wait_cnt_d = wait_cnt_q + WC_W'(1);
            end else begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        end
    end

    assign stall_d = (freeze_pc && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            stall_q    <= stall_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int TMO = 8;
    localparam int CW  = 5;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [3:0]    id_src1, id_src2, exe_dest, mem_dest;
    logic          id_use1, id_use2, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic          mem_acc, mem_ready, branch_taken;
    logic          freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_back, mem_req, mem_err;
    logic [CW-1:0] stall_cycles;
`ifdef PIPE_CTRL_FWD_EN
    logic [3:0]    ex_src1, ex_src2, wb_dest;
    logic          wb_wb_en;
    logic [1:0]    fwd_sel1, fwd_sel2;
    logic [1:0]    e_sel1, e_sel2;
`endif

    wire [5:0] ctrl = {freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_back, mem_req};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .mem_acc      (mem_acc),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
`ifdef PIPE_CTRL_FWD_EN
        .ex_src1      (ex_src1),
        .ex_src2      (ex_src2),
        .wb_dest      (wb_dest),
        .wb_wb_en     (wb_wb_en),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2),
`endif
        .freeze_pc    (freeze_pc),
        .freeze_ifid  (freeze_ifid),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .freeze_back  (freeze_back),
        .mem_req      (mem_req),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: cycles the current access has already been stalled, sticky error, stall count.
    int   m_waited = 0;
    bit   m_err    = 0;
    int   m_cnt    = 0;
    logic [5:0] e_ctrl;
    bit   e_tmo, e_stall;

`ifdef PIPE_CTRL_FWD_EN
    function automatic logic [1:0] ref_sel(input logic [3:0] s);
        if (mem_wb_en && mem_dest == s) return 2'd1;
        if (wb_wb_en && wb_dest == s) return 2'd2;
        return 2'd0;
    endfunction
`endif

    task automatic model_eval();
        bit pend, haz;
        pend    = mem_acc && !mem_ready;
        e_tmo   = pend && (m_waited == TMO);
        e_stall = pend && !e_tmo;
`ifdef PIPE_CTRL_FWD_EN
        haz = exe_mem_r_en && exe_wb_en &&
              ((id_use1 && exe_dest == id_src1) || (id_use2 && exe_dest == id_src2));
        e_sel1 = ref_sel(ex_src1);
        e_sel2 = ref_sel(ex_src2);
`else
        haz = (id_use1 && ((exe_wb_en && exe_dest == id_src1) || (mem_wb_en && mem_dest == id_src1))) ||
              (id_use2 && ((exe_wb_en && exe_dest == id_src2) || (mem_wb_en && mem_dest == id_src2)));
`endif
        e_ctrl = 6'b000000;
        if (!reset) begin
            if (e_stall)           e_ctrl = 6'b110010;
            else if (branch_taken) e_ctrl = 6'b001100;
            else if (haz)          e_ctrl = 6'b110100;
            e_ctrl[0] = mem_acc && !e_tmo;
        end
    endtask

    task automatic settle();
        model_eval();
        #2;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (reset) begin
            m_waited = 0;
            m_err    = 0;
            m_cnt    = 0;
        end else begin
            if (e_tmo) m_err = 1;
            m_waited = e_stall ? m_waited + 1 : 0;
            if (e_ctrl[5] && m_cnt < CNT_MAX) m_cnt++;
        end
        #1;
    endtask

    task automatic idle();
        id_src1 = 4'd0; id_src2 = 4'd0; id_use1 = 1'b0; id_use2 = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0;
        mem_acc = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
`ifdef PIPE_CTRL_FWD_EN
        ex_src1 = 4'd0; ex_src2 = 4'd0; wb_dest = 4'd0; wb_wb_en = 1'b0;
`endif
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        id_src1 = 4'd3; id_use1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        mem_acc = 1'b1; branch_taken = 1'b1;
        settle();
        if (ctrl !== 6'b000000) begin
            errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 6'b000000);
        end
        checks++;
        tick(); tick();
        idle();
        reset = 1'b0;
        settle();
        if (mem_err !== 1'b0) begin
            errors++; $display("FAIL reset_mem_err: got %b want 0", mem_err);
        end
        checks++;
        if (stall_cycles !== '0) begin
            errors++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles);
        end
        checks++;
        tick();
    endtask

    task automatic test_raw_hazard();
        // {use1,src1,use2,src2,exe_dest,exe_wb,exe_rd,mem_dest,mem_wb}
        logic [22:0] tbl [0:7];
        tbl[0] = {1'b1, 4'd3,  1'b0, 4'd0,  4'd3,  1'b1, 1'b0, 4'd0,  1'b0};
        tbl[1] = {1'b1, 4'd3,  1'b0, 4'd0,  4'd3,  1'b1, 1'b1, 4'd0,  1'b0};
        tbl[2] = {1'b0, 4'd3,  1'b0, 4'd0,  4'd3,  1'b1, 1'b1, 4'd0,  1'b0};
        tbl[3] = {1'b1, 4'd3,  1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd3,  1'b1};
        tbl[4] = {1'b0, 4'd0,  1'b1, 4'd7,  4'd7,  1'b0, 1'b1, 4'd7,  1'b0};
        tbl[5] = {1'b1, 4'd2,  1'b1, 4'd15, 4'd15, 1'b1, 1'b1, 4'd1,  1'b1};
        tbl[6] = {1'b1, 4'd2,  1'b1, 4'd5,  4'd6,  1'b1, 1'b1, 4'd9,  1'b1};
        tbl[7] = {1'b1, 4'd4,  1'b1, 4'd9,  4'd1,  1'b1, 1'b0, 4'd9,  1'b1};
        for (int i = 0; i < 8; i++) begin
            idle();
            {id_use1, id_src1, id_use2, id_src2, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en} = tbl[i];
            settle();
            if (ctrl !== e_ctrl) begin
                errors++; $display("FAIL hazard_ctrl[%0d]: got %b want %b", i, ctrl, e_ctrl);
            end
            checks++;
            tick();
        end
        idle();
        settle();
        if (stall_cycles !== CW'(m_cnt)) begin
            errors++; $display("FAIL hazard_stall_cycles: got %0d want %0d", stall_cycles, m_cnt);
        end
        checks++;
`ifdef PIPE_CTRL_FWD_EN
        ex_src1 = 4'd3; ex_src2 = 4'd6;
        mem_dest = 4'd3; mem_wb_en = 1'b1; wb_dest = 4'd3; wb_wb_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) mem_wb_en = 1'b0;
            if (k == 2) wb_dest = 4'd6;
            settle();
            if (fwd_sel1 !== e_sel1 || fwd_sel2 !== e_sel2) begin
                errors++; $display("FAIL fwd_sel[%0d]: got %0d/%0d want %0d/%0d", k, fwd_sel1, fwd_sel2, e_sel1, e_sel2);
            end
            checks++;
            tick();
        end
        idle();
`endif
        tick();
    endtask

    task automatic test_mem_wait();
        int fb, rq;
        fb = 0; rq = 0;
        idle();
        mem_acc = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            mem_ready = (i == 4);
            settle();
            if (ctrl !== e_ctrl) begin
                errors++; $display("FAIL mem_wait_ctrl[%0d]: got %b want %b", i, ctrl, e_ctrl);
            end
            checks++;
            fb += int'(freeze_back);
            rq += int'(mem_req);
            tick();
        end
        if (fb != 4 || rq != 5) begin
            errors++; $display("FAIL mem_wait_counts: freeze_back=%0d mem_req=%0d want 4 and 5", fb, rq);
        end
        checks++;
        mem_ready = 1'b0;
        settle();
        if (ctrl !== e_ctrl) begin
            errors++; $display("FAIL mem_wait_restart: got %b want %b", ctrl, e_ctrl);
        end
        checks++;
        tick();
        mem_ready = 1'b1;
        tick();
        idle();
        tick();
    endtask

    task automatic test_timeout();
        int frz;
        frz = 0;
        idle();
        mem_acc = 1'b1;
        for (int i = 0; i <= TMO; i++) begin
            settle();
            if (ctrl !== e_ctrl) begin
                errors++; $display("FAIL timeout_ctrl[%0d]: got %b want %b", i, ctrl, e_ctrl);
            end
            checks++;
            frz += int'(freeze_back);
            tick();
        end
        mem_acc = 1'b0;
        settle();
        if (mem_err !== 1'b1 || frz != TMO) begin
            errors++; $display("FAIL timeout_err: mem_err=%b frozen=%0d want 1 and %0d", mem_err, frz, TMO);
        end
        checks++;
        for (int i = 0; i < 3; i++) tick();
        mem_acc = 1'b1; mem_ready = 1'b1;
        settle();
        if (mem_err !== 1'b1 || ctrl !== e_ctrl) begin
            errors++; $display("FAIL timeout_sticky: mem_err=%b ctrl=%b want 1 and %b", mem_err, ctrl, e_ctrl);
        end
        checks++;
        tick();
        idle();
        tick();
    endtask

    task automatic test_branch();
        idle();
        id_src1 = 4'd3; id_use1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        branch_taken = 1'b1;
        settle();
        if (ctrl !== 6'b001100 || ctrl !== e_ctrl) begin
            errors++; $display("FAIL branch_over_hazard: got %b want %b", ctrl, e_ctrl);
        end
        checks++;
        tick();
        mem_acc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            settle();
            if (ctrl !== e_ctrl) begin
                errors++; $display("FAIL branch_mem_stall[%0d]: got %b want %b", i, ctrl, e_ctrl);
            end
            checks++;
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_wait();
        idle();
        mem_acc = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        settle();
        if (ctrl !== 6'b000000) begin
            errors++; $display("FAIL midwait_reset_ctrl: got %b want 000000", ctrl);
        end
        checks++;
        tick();
        reset = 1'b0;
        mem_acc = 1'b0;
        settle();
        if (mem_err !== 1'b0 || stall_cycles !== '0) begin
            errors++; $display("FAIL midwait_reset_state: mem_err=%b stall=%0d want 0 and 0", mem_err, stall_cycles);
        end
        checks++;
        tick();
        mem_acc = 1'b1;
        for (int i = 0; i <= TMO; i++) begin
            settle();
            if (ctrl !== e_ctrl) begin
                errors++; $display("FAIL midwait_fresh[%0d]: got %b want %b", i, ctrl, e_ctrl);
            end
            checks++;
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_saturation();
        reset = 1'b1; idle(); tick();
        reset = 1'b0;
        id_src2 = 4'd8; id_use2 = 1'b1; exe_dest = 4'd8; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
        for (int i = 0; i < CNT_MAX + 8; i++) tick();
        idle();
        settle();
        if (stall_cycles !== CW'(CNT_MAX) || m_cnt != CNT_MAX) begin
            errors++; $display("FAIL stall_saturate: got %0d want %0d", stall_cycles, CNT_MAX);
        end
        checks++;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 99) == 0);
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            id_use1      = 1'($urandom_range(0, 1));
            id_use2      = 1'($urandom_range(0, 1));
            exe_dest     = 4'($urandom_range(0, 3));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_dest     = 4'($urandom_range(0, 3));
            mem_wb_en    = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 6) == 0);
            mem_acc      = (m_waited > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            mem_ready    = ((c / 200) % 2 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
`ifdef PIPE_CTRL_FWD_EN
            ex_src1  = 4'($urandom_range(0, 3));
            ex_src2  = 4'($urandom_range(0, 3));
            wb_dest  = 4'($urandom_range(0, 3));
            wb_wb_en = 1'($urandom_range(0, 1));
`endif
            settle();
            if (ctrl !== e_ctrl) begin
                errors++; $display("FAIL rand_ctrl@%0d: got %b want %b", c, ctrl, e_ctrl);
            end
            checks++;
            if (mem_err !== m_err || stall_cycles !== CW'(m_cnt)) begin
                errors++; $display("FAIL rand_state@%0d: err=%b cnt=%0d want %b %0d", c, mem_err, stall_cycles, m_err, m_cnt);
            end
            checks++;
`ifdef PIPE_CTRL_FWD_EN
            if (fwd_sel1 !== e_sel1 || fwd_sel2 !== e_sel2) begin
                errors++; $display("FAIL rand_fwd@%0d: got %0d/%0d want %0d/%0d", c, fwd_sel1, fwd_sel2, e_sel1, e_sel2);
            end
            checks++;
`endif
            tick();
        end
        reset = 1'b0;
        idle();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_raw_hazard();
        test_mem_wait();
        test_timeout();
        test_branch();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
